f2h_sdram_arbiter: RTL
======================

F2H_SDRAM_ARBITER -- requirements
Module: f2h_sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: Avalon-MM byte address width.
REQ-002 SHALL have parameter DATA_W, default 64: data width, multiple of 8.
REQ-003 SHALL have parameter BURST_W, default 8: burstcount width.
REQ-004 SHALL have parameter MAX_PENDING, default 8: outstanding read commands, power of 2.
REQ-005 SHALL have port clk_clk, input, 1: single clock, the h2f clock domain.
REQ-006 SHALL have port reset_reset_n, input, 1: asynchronous assert, active-low reset.
REQ-007 SHALL have port s_address, input, 2*ADDR_W: requester r occupies slice r.
REQ-008 SHALL have port s_read, input, 2: read request per requester.
REQ-009 SHALL have port s_write, input, 2: write request per requester.
REQ-010 SHALL have port s_writedata, input, 2*DATA_W: write data per requester.
REQ-011 SHALL have port s_byteenable, input, 2*DATA_W/8: byte enables per requester.
REQ-012 SHALL have port s_burstcount, input, 2*BURST_W: burst length per requester.
REQ-013 SHALL have port s_waitrequest, output, 2: stall per requester.
REQ-014 SHALL have port s_readdata, output, DATA_W: broadcast read data.
REQ-015 SHALL have port s_readdatavalid, output, 2: read beat valid per requester.
REQ-016 SHALL have downstream ports m_address (out, ADDR_W), m_read (out, 1), m_write (out, 1), m_writedata (out, DATA_W), m_byteenable (out, DATA_W/8), m_burstcount (out, BURST_W), m_waitrequest (in, 1), m_readdata (in, DATA_W) and m_readdatavalid (in, 1): the shared F2H SDRAM port.
REQ-017 SHALL have port err_orphan, output, 1: sticky flag set by readdatavalid with no pending read.

Function
REQ-018 SHALL use an FSM with states IDLE, RD_CMD and WR_BURST, plus register gnt (1 bit) and register last (1 bit).
REQ-019 SHALL treat requester r as requesting in IDLE when s_read[r]|s_write[r]; a read-only request is ineligible while the pending FIFO is full.
REQ-020 SHALL, in IDLE, register the grant on the next edge: if exactly one requester is eligible it wins; if both are eligible the winner is !last.
REQ-021 SHALL, on grant, set last to the winner and enter RD_CMD if s_read is set, else WR_BURST; when both s_read and s_write are set, read wins.
REQ-022 SHALL drive the m_* command outputs combinationally from slice gnt while in RD_CMD or WR_BURST, and drive m_read = m_write = 0 in IDLE.
REQ-023 SHALL drive s_waitrequest[gnt] = m_waitrequest in RD_CMD/WR_BURST; every other s_waitrequest bit SHALL be 1.
REQ-024 SHALL, in RD_CMD, on m_read & !m_waitrequest, push {gnt, burstcount} to the pending FIFO and return to IDLE.
REQ-025 SHALL, in WR_BURST, load beat counter = burstcount on the first accepted beat, decrement it on each accepted beat, and return to IDLE after the final beat.
REQ-026 SHALL treat burstcount 0 as 1.
REQ-027 SHALL route each m_readdatavalid beat to s_readdatavalid[head.id], with s_readdata = m_readdata passed through combinationally.
REQ-028 SHALL pop the FIFO head when its beat count is exhausted.
REQ-029 SHALL perform push and pop together when both occur in the same cycle, leaving occupancy unchanged.
REQ-030 SHALL, on m_readdatavalid with the FIFO empty, drop the beat and set err_orphan, which clears only on reset.
REQ-031 SHALL give a minimum grant latency of 1 cycle: a request seen in IDLE at edge N produces the command on the m_* outputs from edge N+1.
REQ-032 SHALL not preempt a held grant; a requester that drops its request mid-command is a protocol violation and does not return the FSM to IDLE.

Reset
REQ-033 SHALL, while reset_reset_n = 0, force the FSM to IDLE, gnt = 0, last = 1, beat counter = 0, the FIFO empty and err_orphan = 0.
REQ-034 SHALL, while reset_reset_n = 0, hold m_read = m_write = 0, s_waitrequest = 2'b11 and s_readdatavalid = 0.
REQ-035 SHALL abort any in-flight burst or pending read on reset, with no completion reported afterward.

Verification
REQ-036 SHALL verify: both requesters issue single reads continuously from reset -> grants alternate 0,1,0,1, and each s_readdatavalid beat goes to the issuing requester.
REQ-037 SHALL verify: requester 0 issues a write with burstcount 4 while requester 1 requests, and m_waitrequest stalls beat 2 for 3 cycles -> requester 1 is not granted until after beat 4, with the beat counter decrementing 4,3,2,1.
REQ-038 SHALL verify: 8 reads are accepted with no returned data -> a 9th read is stalled (s_waitrequest = 1), and a write from the other requester is still granted.
REQ-039 SHALL verify: a read from requester 0 with burstcount 4 is followed by a read from requester 1 with burstcount 2 -> the first 4 beats go to s_readdatavalid[0] and the next 2 to s_readdatavalid[1].
REQ-040 SHALL verify: m_readdatavalid pulses with the FIFO empty -> err_orphan = 1 and is held until reset.
REQ-041 SHALL verify: reset_reset_n is asserted mid-write-burst -> m_write drops the same cycle (asynchronously), and after release the FSM is IDLE and requester 0 wins the first contention.

Source files
------------

// File: rtl/f2h_sdram_arbiter.sv
// Two-requester arbiter onto one Avalon-MM F2H SDRAM port: alternating grant on contention,
// write bursts held to completion, read returns routed to the issuer through a pending FIFO.
module f2h_sdram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BURST_W     = 8,
    parameter int MAX_PENDING = 8
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [2*ADDR_W-1:0]     s_address,
    input  logic [1:0]              s_read,
    input  logic [1:0]              s_write,
    input  logic [2*DATA_W-1:0]     s_writedata,
    input  logic [2*DATA_W/8-1:0]   s_byteenable,
    input  logic [2*BURST_W-1:0]    s_burstcount,
    output logic [1:0]              s_waitrequest,
    output logic [DATA_W-1:0]       s_readdata,
    output logic [1:0]              s_readdatavalid,
    output logic [ADDR_W-1:0]       m_address,
    output logic                    m_read,
    output logic                    m_write,
    output logic [DATA_W-1:0]       m_writedata,
    output logic [DATA_W/8-1:0]     m_byteenable,
    output logic [BURST_W-1:0]      m_burstcount,
    input  logic                    m_waitrequest,
    input  logic [DATA_W-1:0]       m_readdata,
    input  logic                    m_readdatavalid,
    output logic                    err_orphan,
    output logic [1:0]              o_dbg_state,
    output logic                    o_dbg_gnt,
    output logic [BURST_W-1:0]      o_dbg_beats
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_gnt, w_gnt_nxt;
    logic               r_last, w_last_nxt;
    logic [BURST_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    logic               r_fifo_id [MAX_PENDING];
    logic [BURST_W-1:0] r_fifo_bc [MAX_PENDING];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [BURST_W-1:0] r_rd_beat;
    logic               r_err_orphan;

    logic               w_full, w_empty, w_push, w_pop, w_rvalid;
    logic [1:0]         w_elig;
    logic               w_win;
    logic               w_sel_read, w_sel_write;
    logic [BURST_W-1:0] w_bc_raw, w_bc_eff, w_beats_left;
    logic               w_head_id;
    logic [BURST_W-1:0] w_head_bc;

    // Command fields always follow the granted slice; only m_read/m_write are state-qualified.
    assign m_address    = r_gnt ? s_address[2*ADDR_W-1:ADDR_W]    : s_address[ADDR_W-1:0];
    assign m_writedata  = r_gnt ? s_writedata[2*DATA_W-1:DATA_W]  : s_writedata[DATA_W-1:0];
    assign m_byteenable = r_gnt ? s_byteenable[2*BE_W-1:BE_W]     : s_byteenable[BE_W-1:0];
    assign w_bc_raw     = r_gnt ? s_burstcount[2*BURST_W-1:BURST_W] : s_burstcount[BURST_W-1:0];
    assign w_sel_read   = r_gnt ? s_read[1]  : s_read[0];
    assign w_sel_write  = r_gnt ? s_write[1] : s_write[0];
    assign m_burstcount = w_bc_raw;
    assign w_bc_eff     = (w_bc_raw == '0) ? BURST_W'(1) : w_bc_raw;

    // A zero counter in WR_BURST means the first beat has not been accepted yet.
    assign w_beats_left = (r_beat_cnt == '0) ? w_bc_eff : r_beat_cnt;

    assign w_full  = (r_count == CNT_W'(MAX_PENDING));
    assign w_empty = (r_count == '0);
    assign w_elig  = s_write | (s_read & {2{~w_full}});
    assign w_win   = (w_elig == 2'b11) ? ~r_last : w_elig[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        m_read         = 1'b0;
        m_write        = 1'b0;
        s_waitrequest  = 2'b11;
        w_push         = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_elig) begin
                    w_gnt_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_state_nxt = (w_win ? s_read[1] : s_read[0]) ? RD_CMD : WR_BURST;
                end
            end
            RD_CMD: begin
                // A read+write requester may be granted with the FIFO full; hold the read off until space frees.
                m_read               = w_sel_read & ~w_full;
                s_waitrequest[r_gnt] = m_waitrequest | w_full;
                if (m_read && !m_waitrequest) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                m_write              = w_sel_write;
                s_waitrequest[r_gnt] = m_waitrequest;
                if (m_write && !m_waitrequest) begin
                    if (w_beats_left == BURST_W'(1)) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_beat_cnt_nxt = w_beats_left - BURST_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign w_head_id       = r_fifo_id[r_rd_ptr];
    assign w_head_bc       = r_fifo_bc[r_rd_ptr];
    assign w_rvalid        = m_readdatavalid & ~w_empty;
    assign w_pop           = w_rvalid & ((r_rd_beat + BURST_W'(1)) == w_head_bc);
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = w_rvalid ? (w_head_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= r_gnt;
            r_fifo_bc[r_wr_ptr] <= w_bc_eff;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_beat    <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_rd_beat <= '0;
            end else if (w_rvalid) begin
                r_rd_beat <= r_rd_beat + BURST_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (m_readdatavalid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign err_orphan  = r_err_orphan;
    assign o_dbg_state = r_state;
    assign o_dbg_gnt   = r_gnt;
    assign o_dbg_beats = (r_state == WR_BURST) ? w_beats_left : '0;

endmodule
